// File: rtl/sha256_padder.sv
// SHA-256 message padder: forwards message bytes, then 0x80, zero fill and the
// 64-bit big-endian bit length, so the output is always whole 64-byte blocks.
//
// state   | meaning
// IDLE    | no message in flight, counters cleared, waiting for first byte or msg_empty
// MSG     | forwarding message bytes
// PAD80   | loading the 0x80 terminator
// ZERO    | loading zero fill up to position 55
// LEN     | loading the 8 length bytes, MSB first
// FLUSH   | waiting for the final byte to leave the output register
module sha256_padder (
  input  logic       clk,
  input  logic       rst,
  input  logic       msg_empty,
  input  logic [7:0] msg_data,
  input  logic       msg_valid,
  input  logic       msg_last,
  output logic       msg_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_first,
  output logic       out_last,
  input  logic       out_ready,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MSG,
    S_PAD80,
    S_ZERO,
    S_LEN,
    S_FLUSH
  } state_t;

  state_t      state;
  logic [60:0] byte_cnt;
  logic [5:0]  pos;
  logic [2:0]  len_idx;
  logic        first_pend;

  logic        reg_free;
  logic        out_xfer;
  logic        in_xfer;
  logic [5:0]  next_pos;
  logic [63:0] len_bits;
  logic [63:0] len_shift;
  logic [7:0]  len_byte;

  assign reg_free  = !out_valid || out_ready;
  assign out_xfer  = out_valid && out_ready;
  assign msg_ready = ((state == S_IDLE) || (state == S_MSG)) && reg_free;
  assign in_xfer   = msg_valid && msg_ready;
  assign busy      = (state != S_IDLE);

  // Position the next loaded byte will occupy; a pending byte always leaves
  // before the new one, so this does not depend on out_ready.
  assign next_pos  = pos + {5'b0, out_valid};

  assign len_bits  = {byte_cnt, 3'b000};
  assign len_shift = len_bits << {len_idx, 3'b000};
  assign len_byte  = len_shift[63:56];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      byte_cnt   <= '0;
      pos        <= '0;
      len_idx    <= '0;
      first_pend <= 1'b0;
      out_data   <= 8'h00;
      out_valid  <= 1'b0;
      out_first  <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      if (out_xfer) begin
        out_valid <= 1'b0;
        pos       <= pos + 6'd1;
      end
      case (state)
        S_IDLE: begin
          byte_cnt   <= '0;
          pos        <= '0;
          len_idx    <= '0;
          first_pend <= 1'b0;
          if (in_xfer) begin
            out_data  <= msg_data;
            out_valid <= 1'b1;
            out_first <= 1'b1;
            out_last  <= 1'b0;
            byte_cnt  <= 61'd1;
            state     <= msg_last ? S_PAD80 : S_MSG;
          end else if (msg_empty) begin
            first_pend <= 1'b1;
            state      <= S_PAD80;
          end
        end
        S_MSG: begin
          if (in_xfer) begin
            out_data  <= msg_data;
            out_valid <= 1'b1;
            out_first <= 1'b0;
            byte_cnt  <= byte_cnt + 61'd1;
            if (msg_last) state <= S_PAD80;
          end
        end
        S_PAD80: begin
          if (reg_free) begin
            out_data   <= 8'h80;
            out_valid  <= 1'b1;
            out_first  <= first_pend;
            first_pend <= 1'b0;
            state      <= (next_pos == 6'd55) ? S_LEN : S_ZERO;
          end
        end
        S_ZERO: begin
          if (reg_free) begin
            out_data  <= 8'h00;
            out_valid <= 1'b1;
            out_first <= 1'b0;
            if (next_pos == 6'd55) state <= S_LEN;
          end
        end
        S_LEN: begin
          if (reg_free) begin
            out_data  <= len_byte;
            out_valid <= 1'b1;
            out_first <= 1'b0;
            len_idx   <= len_idx + 3'd1;
            if (len_idx == 3'd7) begin
              out_last <= 1'b1;
              state    <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          if (out_xfer) begin
            out_last <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder: drives messages, captures the padded
// stream and compares it with a bench-side padding model and hand values.
module tb_sha256_padder;

  logic       clk = 1'b0;
  logic       rst;
  logic       msg_empty;
  logic [7:0] msg_data;
  logic       msg_valid;
  logic       msg_last;
  logic       msg_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_first;
  logic       out_last;
  logic       out_ready;
  logic       busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] msg_mem [0:255];
  logic [7:0] cap_data [0:255];
  logic       cap_first [0:255];
  logic       cap_last [0:255];
  int         cap_n;
  int         first_acc;

  always #5 clk = ~clk;

  sha256_padder dut (
    .clk       (clk),
    .rst       (rst),
    .msg_empty (msg_empty),
    .msg_data  (msg_data),
    .msg_valid (msg_valid),
    .msg_last  (msg_last),
    .msg_ready (msg_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_first (out_first),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic send(input int n, input bit empty, input bit stall, input int abort_at);
    int         idx = 0;
    int         cyc = 0;
    bit         done = 0;
    bit         held_v = 0;
    logic [7:0] hd = 0;
    logic       hf = 0;
    logic       hl = 0;
    cap_n = 0;
    first_acc = -1;
    while (!done && cyc < 1000) begin
      msg_valid = (idx < n);
      msg_data  = (idx < n) ? msg_mem[idx] : 8'h00;
      msg_last  = (idx == n - 1);
      msg_empty = empty && (cyc == 0);
      out_ready = stall ? ((cyc % 4) == 3) : 1'b1;
      #4;
      if (held_v) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_data", out_data, hd);
        chk("stall_first", out_first, hf);
        chk("stall_last", out_last, hl);
      end
      held_v = out_valid && !out_ready;
      if (held_v) begin
        chk("stall_msg_ready", msg_ready, 1'b0);
        hd = out_data;
        hf = out_first;
        hl = out_last;
      end
      if (msg_valid && msg_ready) begin
        if (first_acc < 0) first_acc = cyc;
        idx++;
      end
      if (out_valid && out_ready) begin
        cap_data[cap_n]  = out_data;
        cap_first[cap_n] = out_first;
        cap_last[cap_n]  = out_last;
        cap_n++;
        if (out_last) done = 1;
      end
      if (abort_at >= 0 && cap_n == abort_at) done = 1;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    msg_valid = 1'b0;
    msg_empty = 1'b0;
    msg_last  = 1'b0;
    out_ready = 1'b1;
    if (!done) chk("timeout", 64'd0, 64'd1);
    else if (abort_at < 0) chk("bytes_consumed", idx, n);
  endtask

  function automatic logic [7:0] exp_byte(input int i, input int n);
    int          total;
    logic [63:0] l;
    total = 64 * ((n + 9 + 63) / 64);
    l = 64'(n) * 64'd8;
    if (i < n) return msg_mem[i];
    if (i == n) return 8'h80;
    if (i >= total - 8) return l[8*(total-1-i) +: 8];
    return 8'h00;
  endfunction

  task automatic check_stream(input string tag, input int n, input int exp_total);
    chk($sformatf("%s_len", tag), cap_n, exp_total);
    for (int i = 0; i < exp_total && i < cap_n; i++) begin
      chk($sformatf("%s_data[%0d]", tag, i), cap_data[i], exp_byte(i, n));
      chk($sformatf("%s_first[%0d]", tag, i), cap_first[i], (i == 0));
      chk($sformatf("%s_last[%0d]", tag, i), cap_last[i], (i == exp_total - 1));
    end
  endtask

  task automatic load_abc();
    msg_mem[0] = 8'h61;
    msg_mem[1] = 8'h62;
    msg_mem[2] = 8'h63;
  endtask

  initial begin
    rst = 1'b1;
    msg_empty = 1'b0;
    msg_data = 8'h00;
    msg_valid = 1'b0;
    msg_last = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_first", out_first, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_msg_ready", msg_ready, 1'b1);

    // "abc"
    load_abc();
    send(3, 0, 0, -1);
    check_stream("abc", 3, 64);
    chk("abc_b3", cap_data[3], 8'h80);
    chk("abc_b62", cap_data[62], 8'h00);
    chk("abc_b63", cap_data[63], 8'h18);
    chk("abc_busy_after", busy, 1'b0);

    // empty message
    send(0, 1, 0, -1);
    check_stream("empty", 0, 64);
    chk("empty_b0", cap_data[0], 8'h80);
    chk("empty_b63", cap_data[63], 8'h00);

    // 55 and 56 byte boundary
    for (int i = 0; i < 256; i++) msg_mem[i] = 8'(i + 1);
    send(55, 0, 0, -1);
    check_stream("m55", 55, 64);
    chk("m55_b55", cap_data[55], 8'h80);
    chk("m55_b62", cap_data[62], 8'h01);
    chk("m55_b63", cap_data[63], 8'hB8);
    send(56, 0, 0, -1);
    check_stream("m56", 56, 128);
    chk("m56_b56", cap_data[56], 8'h80);
    chk("m56_b126", cap_data[126], 8'h01);
    chk("m56_b127", cap_data[127], 8'hC0);

    // 100 bytes, unstalled then with 3-low/1-high stalls
    for (int i = 0; i < 256; i++) msg_mem[i] = 8'(i) ^ 8'h5A;
    send(100, 0, 0, -1);
    check_stream("m100", 100, 128);
    chk("m100_b100", cap_data[100], 8'h80);
    chk("m100_b126", cap_data[126], 8'h03);
    chk("m100_b127", cap_data[127], 8'h20);
    send(100, 0, 1, -1);
    check_stream("m100s", 100, 128);

    // reset at output byte 20, then "abc" again
    send(100, 0, 0, 20);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    rst = 1'b0;
    load_abc();
    send(3, 0, 0, -1);
    check_stream("abc2", 3, 64);
    chk("abc2_b63", cap_data[63], 8'h18);

    // back-to-back "a" then "b"
    msg_mem[0] = 8'h61;
    send(1, 0, 0, -1);
    check_stream("a", 1, 64);
    chk("a_b63", cap_data[63], 8'h08);
    msg_mem[0] = 8'h62;
    chk("b_idle_busy", busy, 1'b0);
    send(1, 0, 0, -1);
    chk("b_first_accept_cycle", first_acc, 0);
    check_stream("b", 1, 64);
    chk("b_b0", cap_data[0], 8'h62);
    chk("b_b1", cap_data[1], 8'h80);
    chk("b_b63", cap_data[63], 8'h08);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha256_padder.md
# sha256_padder

Upstream stage of the SHA-256 byte pipeline. It accepts a raw message as a byte stream and emits the FIPS 180-4 padded stream to the block processor: message bytes, then 0x80, then zero fill, then the 64-bit big-endian bit length. The processor does no padding of its own, so this block guarantees that its output is always a whole number of 64-byte blocks, with the final byte flagged.

## Interface

Parameters:
- none. Block size (64 bytes) and length field (64 bits) are fixed by SHA-256.

Ports:
- `clk`  in  1  single clock; everything is synchronous to the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `msg_empty`  in  1  one-cycle pulse in IDLE: the message has zero length.
- `msg_data`  in  8  message byte.
- `msg_valid`  in  1  `msg_data` is valid.
- `msg_last`  in  1  with `msg_valid`: this is the final message byte.
- `msg_ready`  out  1  the padder accepts a message byte this cycle.
- `out_data`  out  8  padded stream byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_first`  out  1  with `out_valid`: first byte of the padded message. The integrator drives the processor's `start` from `out_valid & out_first`.
- `out_last`  out  1  with `out_valid`: final byte of the padded message. Drives the processor's `data_last`.
- `out_ready`  in  1  the downstream stage accepts `out_data`. Connects to the processor's `in_ready`.
- `busy`  out  1  high whenever the block is not in IDLE.

## Operation

- Transfer rules:
  - Input transfer: `msg_valid & msg_ready`.
  - Output transfer: `out_valid & out_ready`.
- Output stage is a single register. Once `out_valid` is high, `out_data`, `out_first` and `out_last` are held stable until the output transfer completes.
- The register is free when `!out_valid | out_ready`.
- `msg_ready` = (state == IDLE or MSG) & output register free.
- Counters:
  - `byte_cnt`: 61-bit count of message bytes accepted. Wraps mod 2^61.
  - `pos`: 6-bit count of output bytes transferred. Wraps mod 64.
  - `len_idx`: 3-bit index into the length field.
- Length field L = {`byte_cnt`, 3'b000}, sent most-significant byte first.
- FSM states: IDLE, MSG, PAD80, ZERO, LEN, FLUSH.
- IDLE:
  - Clears `byte_cnt`, `pos` and `len_idx`.
  - Accepted byte: load it into the output register with `out_first=1` and set `byte_cnt`=1. Go to PAD80 if `msg_last`, otherwise to MSG.
  - `msg_empty` with no byte: go to PAD80 and mark the first padded byte with `out_first=1`.
  - `msg_empty` together with `msg_valid`: the byte wins and `msg_empty` is ignored.
- MSG: each accepted byte is loaded into the output register and increments `byte_cnt`. On `msg_last`, go to PAD80.
- PAD80: when the register is free, load 0x80. Then go to LEN if the post-transfer position of that byte equals 56, otherwise go to ZERO.
- ZERO: load 0x00 whenever the register is free, until the next byte loaded would occupy position 56; then go to LEN.
  - Positions are computed from `pos` plus the pending byte in the register, so the decision never depends on `out_ready`.
- LEN: load byte `len_idx` of L, 8 bytes in total. On the 8th byte set `out_last=1` and go to FLUSH.
- FLUSH: wait for the final output transfer, then go to IDLE.
- Message bytes presented outside IDLE/MSG are not accepted (`msg_ready=0`).

## Timing

- Reset values:
  - state IDLE.
  - `out_valid`, `out_first`, `out_last`, `busy` = 0.
  - `out_data` = 0x00.
  - `msg_ready` = 1, because the output register is empty in IDLE.
- Reset has priority over every other event. A reset mid-message drops all state and pending output; `out_valid` is 0 on the cycle after reset.
- Latency: an accepted byte appears on `out_data` the next cycle.
- Throughput: one byte per cycle under continuous `out_ready`. There is no bubble between the last message byte and 0x80, or between padding phases.
- Backpressure: while `out_ready=0` with `out_valid=1`, all outputs hold and `msg_ready=0`.
- Padded length in bytes: 64 × ceil((n+9)/64) for message length n.
  - n mod 64 ≤ 55: one extra block.
  - n mod 64 in 56..63: padding spills into a second block.
- `busy` goes to 0 on the cycle after the `out_last` transfer. A new `msg_valid` is accepted in that same IDLE cycle.

## Test plan

- "abc" (61 62 63, last on 63), `out_ready`=1 -> 64 bytes: 61 62 63 80, 52×00, then 00 00 00 00 00 00 00 18. `out_first` on byte 0, `out_last` on byte 63. Feeding the processor gives hash ba7816bf…f20015ad.
- `msg_empty` pulse -> 80, 55×00, 8×00. `out_first` on the 80, `out_last` on byte 63, 64 bytes total.
- 55-byte message -> exactly 64 bytes, 0x80 at position 55, length 00…01 B8. 56-byte message -> 128 bytes, 0x80 at position 56, length 00…01 C0 ending at byte 127.
- Random `out_ready` stalls (for example 3 low, 1 high) on a 100-byte message -> byte sequence identical to the unstalled run. Outputs are stable through every stall, and no input byte is dropped or duplicated.
- Reset asserted at output byte 20 of a message -> next cycle `out_valid`=0, `busy`=0. A following "abc" produces the exact vector from the first scenario.
- Back-to-back messages "a" then "b" -> two 64-byte padded streams, each with its own `out_first` and `out_last`. The second stream's length field is 00…08 (not 10).
